dump_sequencer: RTL and testbench

- Streams the MIPS register bank and data memory contents out through the UART TX FIFO as a flat byte sequence.
- Sits between the debugger and the uart instance; the debugger pulses i_start once the program ends or a step completes.
- The MIPS core is held disabled for the whole dump, so input buses are stable while o_busy=1. The block does not snapshot them.

---
 rtl/dump_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_dump_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dump_sequencer.sv
// Streams the register bank then data memory, MSB-first per word, into the UART TX FIFO.
// Optional DUMP_CHECKSUM_EN appends one XOR-of-all-bytes trailer before completion.
module dump_sequencer #(
    parameter int unsigned UART_BUS_SIZE          = 8,
    parameter int unsigned REGISTER_SIZE          = 32,
    parameter int unsigned REGISTER_BANK_BUS_SIZE = 1024,
    parameter int unsigned MEMORY_SLOT_SIZE       = 32,
    parameter int unsigned MEMORY_DATA_BUS_SIZE   = 1024
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic                              i_start,
    input  logic                              i_uart_full,
    input  logic [REGISTER_BANK_BUS_SIZE-1:0] i_registers,
    input  logic [MEMORY_DATA_BUS_SIZE-1:0]   i_memory,
    output logic                              o_uart_wr,
    output logic [UART_BUS_SIZE-1:0]          o_uart_data_wr,
    output logic                              o_busy,
    output logic                              o_done
);

    localparam int unsigned REG_BYTES = REGISTER_BANK_BUS_SIZE / UART_BUS_SIZE;
    localparam int unsigned MEM_BYTES = MEMORY_DATA_BUS_SIZE / UART_BUS_SIZE;
    localparam int unsigned MAX_BYTES = (REG_BYTES > MEM_BYTES) ? REG_BYTES : MEM_BYTES;
    localparam int unsigned IDX_W     = $clog2(MAX_BYTES + 1);
    localparam int unsigned REG_BPW   = REGISTER_SIZE / UART_BUS_SIZE;
    localparam int unsigned MEM_BPW   = MEMORY_SLOT_SIZE / UART_BUS_SIZE;
    localparam int unsigned REG_LSB_W = $clog2(REGISTER_BANK_BUS_SIZE);
    localparam int unsigned MEM_LSB_W = $clog2(MEMORY_DATA_BUS_SIZE);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REGS   = 3'd1;
    localparam logic [2:0] ST_MEM    = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;
    localparam logic [2:0] ST_CSUM   = 3'd5;

`ifdef DUMP_CHECKSUM_EN
    localparam logic [2:0] MEM_DONE_RET = ST_CSUM;
`else
    localparam logic [2:0] MEM_DONE_RET = ST_FINISH;
`endif

    logic [2:0]               state_q, state_d;
    logic [2:0]               ret_q, ret_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     uart_wr_q, uart_wr_d;
    logic [UART_BUS_SIZE-1:0] uart_data_q, uart_data_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
`ifdef DUMP_CHECKSUM_EN
    logic [UART_BUS_SIZE-1:0] csum_q, csum_d;
`endif

    logic [REG_LSB_W-1:0]     reg_lsb;
    logic [MEM_LSB_W-1:0]     mem_lsb;
    logic [UART_BUS_SIZE-1:0] reg_byte;
    logic [UART_BUS_SIZE-1:0] mem_byte;
    int unsigned              idx_i;

    // Byte idx of a section: word idx/BPW, MSB byte first within the word.
    always_comb begin
        idx_i    = 32'(idx_q);
        reg_lsb  = REG_LSB_W'((idx_i / REG_BPW) * REGISTER_SIZE
                              + (REG_BPW - 1 - (idx_i % REG_BPW)) * UART_BUS_SIZE);
        mem_lsb  = MEM_LSB_W'((idx_i / MEM_BPW) * MEMORY_SLOT_SIZE
                              + (MEM_BPW - 1 - (idx_i % MEM_BPW)) * UART_BUS_SIZE);
        reg_byte = i_registers[reg_lsb +: UART_BUS_SIZE];
        mem_byte = i_memory[mem_lsb +: UART_BUS_SIZE];
    end

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        idx_d       = idx_q;
        uart_wr_d   = 1'b0;
        uart_data_d = uart_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef DUMP_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_REGS;
                    idx_d   = '0;
                    busy_d  = 1'b1;
`ifdef DUMP_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            ST_REGS: begin
                if (!i_uart_full) begin
                    uart_wr_d   = 1'b1;
                    uart_data_d = reg_byte;
`ifdef DUMP_CHECKSUM_EN
                    csum_d      = csum_q ^ reg_byte;
`endif
                    state_d     = ST_GAP;
                    if (idx_q == IDX_W'(REG_BYTES - 1)) begin
                        idx_d = '0;
                        ret_d = ST_MEM;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        ret_d = ST_REGS;
                    end
                end
            end
            ST_MEM: begin
                if (!i_uart_full) begin
                    uart_wr_d   = 1'b1;
                    uart_data_d = mem_byte;
`ifdef DUMP_CHECKSUM_EN
                    csum_d      = csum_q ^ mem_byte;
`endif
                    state_d     = ST_GAP;
                    if (idx_q == IDX_W'(MEM_BYTES - 1)) begin
                        idx_d = '0;
                        ret_d = MEM_DONE_RET;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        ret_d = ST_MEM;
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            ST_CSUM: begin
                if (!i_uart_full) begin
                    uart_wr_d   = 1'b1;
                    uart_data_d = csum_q;
                    state_d     = ST_GAP;
                    ret_d       = ST_FINISH;
                end
            end
`endif
            // Idle cycle lets a FIFO-full caused by the last write reach us.
            ST_GAP: begin
                state_d = ret_q;
                if (ret_q == ST_FINISH) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            ret_q       <= ST_IDLE;
            idx_q       <= '0;
            uart_wr_q   <= 1'b0;
            uart_data_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            idx_q       <= idx_d;
            uart_wr_q   <= uart_wr_d;
            uart_data_q <= uart_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef DUMP_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign o_uart_wr      = uart_wr_q;
    assign o_uart_data_wr = uart_data_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;

endmodule

// File: tb/tb_dump_sequencer.sv
// Directed bench for dump_sequencer: stream content, backpressure, ignored starts, reset abort.
module tb_dump_sequencer;

`ifdef DUMP_CHECKSUM_EN
    localparam int STREAM_LEN = 257;
`else
    localparam int STREAM_LEN = 256;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          full = 1'b0;
    logic [1023:0] regs_bus = '0;
    logic [1023:0] mem_bus = '0;
    logic          o_uart_wr;
    logic [7:0]    o_uart_data_wr;
    logic          o_busy;
    logic          o_done;

    logic [31:0] regs_w [32];
    logic [31:0] mem_w  [32];
    logic [7:0]  rx_q [$];
    int vectors = 0;
    int errors  = 0;
    int done_cnt, gap_bad, full_bad, done_busy_bad;
    logic prev_wr = 1'b0;
    logic full_s  = 1'b0;

    always #5 clk = ~clk;

    dump_sequencer dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_start        (start),
        .i_uart_full    (full),
        .i_registers    (regs_bus),
        .i_memory       (mem_bus),
        .o_uart_wr      (o_uart_wr),
        .o_uart_data_wr (o_uart_data_wr),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    always @(posedge clk) full_s <= full;

    // Byte capture plus protocol watchers (back-to-back strobes, strobe while full, done with busy).
    always @(negedge clk) begin
        if (rst) begin
            prev_wr = 1'b0;
        end else begin
            if (o_uart_wr) begin
                rx_q.push_back(o_uart_data_wr);
                if (prev_wr) gap_bad++;
                if (full_s) full_bad++;
            end
            if (o_done) begin
                done_cnt++;
                if (o_busy) done_busy_bad++;
            end
            prev_wr = o_uart_wr;
        end
    end

    function automatic logic [7:0] exp_byte(int k);
        logic [31:0] w;
        if (k < 128) w = regs_w[k/4];
        else         w = mem_w[(k-128)/4];
        return w[31 - 8*(k%4) -: 8];
    endfunction

    function automatic logic [7:0] rx_at(int k);
        if (k < rx_q.size()) return rx_q[k];
        return 8'hxx;
    endfunction

    function automatic int stream_errs();
        int bad = 0;
        for (int k = 0; k < 256; k++) if (rx_at(k) !== exp_byte(k)) bad++;
        return bad;
    endfunction

    task automatic load_pattern(input bit csum_pat);
        for (int k = 0; k < 32; k++) begin
            regs_w[k] = csum_pat ? 32'h0 : 32'h1000_0000 + 32'(k);
            mem_w[k]  = csum_pat ? 32'h0 : 32'hC0DE_0000 + 32'(k);
        end
        if (csum_pat) begin
            regs_w[1] = 32'h0000_00FF;
            mem_w[0]  = 32'h0F00_0000;
        end
        for (int k = 0; k < 32; k++) begin
            regs_bus[k*32 +: 32] = regs_w[k];
            mem_bus[k*32 +: 32]  = mem_w[k];
        end
    endtask

    task automatic clear_mon();
        rx_q.delete();
        done_cnt = 0; gap_bad = 0; full_bad = 0; done_busy_bad = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(output bit to);
        to = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (done_cnt > 0) begin to = 1'b0; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_bytes(input int n, output bit to);
        to = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (rx_q.size() >= n) begin to = 1'b0; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; full = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (o_uart_wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %b want 0", o_uart_wr); end
        vectors++; if (o_uart_data_wr !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", o_uart_data_wr); end
        vectors++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
        vectors++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", o_done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] exp_head [8] = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h01};
        logic [7:0] exp_mem  [4] = '{8'hC0, 8'hDE, 8'h00, 8'h00};
        bit to;
        load_pattern(1'b0);
        clear_mon();
        pulse_start();
        vectors++; if (o_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_start got %b want 1", o_busy); end
        vectors++; if (o_uart_wr !== 1'b0) begin errors++; $display("FAIL basic_no_early_strobe got %b want 0", o_uart_wr); end
        wait_done(to);
        vectors++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout got timeout want done"); end
        vectors++; if (rx_q.size() !== STREAM_LEN) begin errors++; $display("FAIL basic_len got %0d want %0d", rx_q.size(), STREAM_LEN); end
        for (int k = 0; k < 8; k++) begin
            vectors++; if (rx_at(k) !== exp_head[k]) begin errors++; $display("FAIL basic_byte%0d got %h want %h", k, rx_at(k), exp_head[k]); end
        end
        for (int k = 0; k < 4; k++) begin
            vectors++; if (rx_at(128+k) !== exp_mem[k]) begin errors++; $display("FAIL basic_byte%0d got %h want %h", 128+k, rx_at(128+k), exp_mem[k]); end
        end
        vectors++; if (rx_at(255) !== 8'h1F) begin errors++; $display("FAIL basic_byte255 got %h want 1f", rx_at(255)); end
        vectors++; if (stream_errs() !== 0) begin errors++; $display("FAIL basic_stream got %0d bad bytes want 0", stream_errs()); end
        vectors++; if (gap_bad !== 0) begin errors++; $display("FAIL basic_gap got %0d back-to-back want 0", gap_bad); end
        vectors++; if (done_busy_bad !== 0) begin errors++; $display("FAIL basic_done_busy got %0d want 0", done_busy_bad); end
        repeat (4) @(negedge clk);
        vectors++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", done_cnt); end
        vectors++; if (o_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b want 0", o_busy); end
    endtask

    task automatic test_backpressure();
        bit to;
        int held;
        load_pattern(1'b0);
        clear_mon();
        pulse_start();
        wait_bytes(10, to);
        vectors++; if (to !== 1'b0) begin errors++; $display("FAIL bp_reach10 got timeout want 10 bytes"); end
        full = 1'b1;
        held = rx_q.size();
        repeat (30) @(negedge clk);
        vectors++; if (rx_q.size() !== held) begin errors++; $display("FAIL bp_hold got %0d bytes want %0d", rx_q.size(), held); end
        full = 1'b0;
        wait_done(to);
        vectors++; if (to !== 1'b0) begin errors++; $display("FAIL bp_timeout got timeout want done"); end
        vectors++; if (rx_q.size() !== STREAM_LEN) begin errors++; $display("FAIL bp_len got %0d want %0d", rx_q.size(), STREAM_LEN); end
        vectors++; if (stream_errs() !== 0) begin errors++; $display("FAIL bp_stream got %0d bad bytes want 0", stream_errs()); end
        vectors++; if (full_bad !== 0) begin errors++; $display("FAIL bp_wr_while_full got %0d want 0", full_bad); end
        vectors++; if (done_cnt !== 1) begin errors++; $display("FAIL bp_done_count got %0d want 1", done_cnt); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_restart_ignored();
        bit p5 = 1'b0, p200 = 1'b0, to = 1'b1;
        load_pattern(1'b0);
        clear_mon();
        pulse_start();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done_cnt > 0) begin to = 1'b0; break; end
            if (!p5 && rx_q.size() >= 5) begin start = 1'b1; p5 = 1'b1; end
            if (!p200 && rx_q.size() >= 200) begin start = 1'b1; p200 = 1'b1; end
        end
        start = 1'b0;
        repeat (20) @(negedge clk);
        vectors++; if (to !== 1'b0) begin errors++; $display("FAIL restart_timeout got timeout want done"); end
        vectors++; if (rx_q.size() !== STREAM_LEN) begin errors++; $display("FAIL restart_len got %0d want %0d", rx_q.size(), STREAM_LEN); end
        vectors++; if (stream_errs() !== 0) begin errors++; $display("FAIL restart_stream got %0d bad bytes want 0", stream_errs()); end
        vectors++; if (done_cnt !== 1) begin errors++; $display("FAIL restart_done_count got %0d want 1", done_cnt); end
        vectors++; if (o_busy !== 1'b0) begin errors++; $display("FAIL restart_busy got %b want 0", o_busy); end
    endtask

    task automatic test_reset_mid();
        bit to;
        load_pattern(1'b0);
        clear_mon();
        pulse_start();
        wait_bytes(50, to);
        vectors++; if (to !== 1'b0) begin errors++; $display("FAIL rstmid_reach50 got timeout want 50 bytes"); end
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (o_uart_wr !== 1'b0) begin errors++; $display("FAIL rstmid_wr got %b want 0", o_uart_wr); end
        vectors++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", o_busy); end
        vectors++; if (o_done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", o_done); end
        rst = 1'b0;
        clear_mon();
        repeat (10) @(negedge clk);
        vectors++; if (rx_q.size() !== 0) begin errors++; $display("FAIL rstmid_no_resume got %0d bytes want 0", rx_q.size()); end
        pulse_start();
        wait_done(to);
        vectors++; if (rx_at(0) !== 8'h10) begin errors++; $display("FAIL rstmid_first got %h want 10", rx_at(0)); end
        vectors++; if (rx_q.size() !== STREAM_LEN) begin errors++; $display("FAIL rstmid_len got %0d want %0d", rx_q.size(), STREAM_LEN); end
        vectors++; if (stream_errs() !== 0) begin errors++; $display("FAIL rstmid_stream got %0d bad bytes want 0", stream_errs()); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_full_at_start();
        bit to;
        int not_busy = 0;
        load_pattern(1'b0);
        clear_mon();
        full = 1'b1;
        repeat (2) @(negedge clk);
        pulse_start();
        for (int c = 0; c < 100; c++) begin
            if (o_busy !== 1'b1) not_busy++;
            @(negedge clk);
        end
        vectors++; if (not_busy !== 0) begin errors++; $display("FAIL fullstart_busy got %0d non-busy cycles want 0", not_busy); end
        vectors++; if (rx_q.size() !== 0) begin errors++; $display("FAIL fullstart_strobes got %0d want 0", rx_q.size()); end
        full = 1'b0;
        @(negedge clk);
        vectors++; if (o_uart_wr !== 1'b1) begin errors++; $display("FAIL fullstart_first_wr got %b want 1", o_uart_wr); end
        vectors++; if (o_uart_data_wr !== 8'h10) begin errors++; $display("FAIL fullstart_first_data got %h want 10", o_uart_data_wr); end
        wait_done(to);
        vectors++; if (rx_q.size() !== STREAM_LEN) begin errors++; $display("FAIL fullstart_len got %0d want %0d", rx_q.size(), STREAM_LEN); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_checksum();
        bit to;
        load_pattern(1'b1);
        clear_mon();
        pulse_start();
        wait_done(to);
        vectors++; if (to !== 1'b0) begin errors++; $display("FAIL csum_timeout got timeout want done"); end
        vectors++; if (rx_at(7) !== 8'hFF) begin errors++; $display("FAIL csum_byte7 got %h want ff", rx_at(7)); end
        vectors++; if (rx_at(128) !== 8'h0F) begin errors++; $display("FAIL csum_byte128 got %h want 0f", rx_at(128)); end
        vectors++; if (rx_q.size() !== STREAM_LEN) begin errors++; $display("FAIL csum_len got %0d want %0d", rx_q.size(), STREAM_LEN); end
`ifdef DUMP_CHECKSUM_EN
        vectors++; if (rx_at(256) !== 8'hF0) begin errors++; $display("FAIL csum_trailer got %h want f0", rx_at(256)); end
`endif
        repeat (3) @(negedge clk);
        vectors++; if (done_cnt !== 1) begin errors++; $display("FAIL csum_done_count got %0d want 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_restart_ignored();
        test_reset_mid();
        test_full_at_start();
        test_checksum();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
